hazard_unit_mc: RTL and testbench

- Parametrised hazard unit for the 5-stage MIPS pipeline.
- Generalises operand checking to NUM_SRC sources per instruction; source 2 is the Rd read of three-operand ops such as WGHT.
- Adds a scoreboard for one multi-cycle execute unit (MUL/DIV class) with a latency counter, structural and RAW stalls, a protocol-error flag and a saturating stall counter.
- Sits beside the datapath; drives the stall, flush and forward selects for all stages.

---
 rtl/hazard_unit_mc.sv | 199 +++++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - hazard unit with multi-source forwarding and a multi-cycle execute scoreboard
//
// Purpose: detects data and structural hazards for a 5-stage MIPS pipeline and
// drives the stall, flush and forwarding selects for every stage. Each
// instruction may read up to NUM_SRC registers. One multi-cycle execute unit
// (MUL/DIV class) is tracked by a small IDLE/BUSY scoreboard.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   BranchD                     branch in Decode
//   SrcD / SrcValidD            Decode source registers and read enables
//   SrcE / SrcValidE            Execute source registers and read enables
//   McStartD                    Decode holds a multi-cycle op
//   McStartE / McDestE          multi-cycle issue in Execute and its destination
//   MemtoRegE, MemtoRegM        load in E / M
//   RegWriteE/M/W, WriteRegE/M/W  register writes and destinations in E / M / W
//   StallF, StallD, FlushE      pipeline control
//   ForwardD                    per-source ALUOutM select for the branch compare
//   ForwardE                    per-source select: 00 regfile, 01 ResultW, 10 ALUOutM
//   McBusy, McDone, McErr       multi-cycle unit occupied / result written / protocol error
//   StallCount                  saturating count of cycles with StallD high

module hazard_unit_mc #(
    parameter int REG_W       = 5,
    parameter int NUM_SRC     = 3,
    parameter int MC_LATENCY  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       BranchD,
    input  logic [NUM_SRC*REG_W-1:0]   SrcD,
    input  logic [NUM_SRC-1:0]         SrcValidD,
    input  logic [NUM_SRC*REG_W-1:0]   SrcE,
    input  logic [NUM_SRC-1:0]         SrcValidE,
    input  logic                       McStartD,
    input  logic                       McStartE,
    input  logic [REG_W-1:0]           McDestE,
    input  logic                       MemtoRegE,
    input  logic                       MemtoRegM,
    input  logic                       RegWriteE,
    input  logic                       RegWriteM,
    input  logic                       RegWriteW,
    input  logic [REG_W-1:0]           WriteRegE,
    input  logic [REG_W-1:0]           WriteRegM,
    input  logic [REG_W-1:0]           WriteRegW,
    output logic                       StallF,
    output logic                       StallD,
    output logic                       FlushE,
    output logic [NUM_SRC-1:0]         ForwardD,
    output logic [2*NUM_SRC-1:0]       ForwardE,
    output logic                       McBusy,
    output logic                       McDone,
    output logic                       McErr,
    output logic [STALL_CNT_W-1:0]     StallCount
);

    localparam int CNT_W  = $clog2(MC_LATENCY);
    // Branch compares only read Rs and Rt.
    localparam int BR_SRC = (NUM_SRC < 2) ? NUM_SRC : 2;
    // Counter holds remaining busy cycles after the first; zero marks the McDone cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    mc_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_W-1:0]   dest_q, dest_d;
    logic               err_q, err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic lwstall, branchstall, mcrawstall, mcstructstall, stall;

    // Register 0 is hardwired and never creates a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

    // Scoreboard next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        err_d   = err_q;
        case (state_q)
            MC_IDLE: begin
                if (McStartE) begin
                    state_d = MC_BUSY;
                    cnt_d   = CNT_LOAD;
                    dest_d  = McDestE;
                end
            end
            MC_BUSY: begin
                if (cnt_q == '0) begin
                    // Result is written this cycle, so a new issue can follow back-to-back.
                    if (McStartE) begin
                        cnt_d  = CNT_LOAD;
                        dest_d = McDestE;
                    end else begin
                        state_d = MC_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    // Issue into an occupied unit: keep the in-flight op, flag the violation.
                    if (McStartE) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
    end

    // Scoreboard outputs
    always_comb begin
        McBusy = (state_q == MC_BUSY);
        McDone = (state_q == MC_BUSY) && (cnt_q == '0);
        McErr  = err_q;
    end

    // Forwarding selects
    always_comb begin
        ForwardE = '0;
        ForwardD = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SrcValidE[i] && RegWriteM && reg_match(WriteRegM, SrcE[i*REG_W +: REG_W])) begin
                ForwardE[2*i +: 2] = 2'b10;
            end else if (SrcValidE[i] && RegWriteW && reg_match(WriteRegW, SrcE[i*REG_W +: REG_W])) begin
                ForwardE[2*i +: 2] = 2'b01;
            end
            ForwardD[i] = SrcValidD[i] && RegWriteM && reg_match(WriteRegM, SrcD[i*REG_W +: REG_W]);
        end
    end

    // Stall detection
    always_comb begin
        lwstall     = 1'b0;
        branchstall = 1'b0;
        mcrawstall  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SrcValidD[i] && reg_match(WriteRegE, SrcD[i*REG_W +: REG_W])) begin
                lwstall = lwstall | MemtoRegE;
            end
            if (SrcValidD[i] && reg_match(dest_q, SrcD[i*REG_W +: REG_W])) begin
                mcrawstall = 1'b1;
            end
        end
        for (int i = 0; i < BR_SRC; i++) begin
            if (SrcValidD[i]) begin
                if (RegWriteE && reg_match(WriteRegE, SrcD[i*REG_W +: REG_W])) begin
                    branchstall = 1'b1;
                end
                if (MemtoRegM && reg_match(WriteRegM, SrcD[i*REG_W +: REG_W])) begin
                    branchstall = 1'b1;
                end
            end
        end
        branchstall = branchstall & BranchD;
        // In the McDone cycle the register file writes first-half, so no stall is needed.
        mcrawstall    = mcrawstall & McBusy & ~McDone;
        mcstructstall = McStartD & McBusy & ~McDone;
        stall         = lwstall | branchstall | mcrawstall | mcstructstall;
        StallF        = stall;
        StallD        = stall;
        FlushE        = stall;
    end

    // Saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (StallD && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - directed self-checking bench for hazard_unit_mc

module tb_hazard_unit_mc;

    localparam int REG_W = 5;
    localparam int NUM_SRC = 3;
    localparam int MC_LATENCY = 4;
    localparam int STALL_CNT_W = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     BranchD;
    logic [NUM_SRC*REG_W-1:0] SrcD;
    logic [NUM_SRC-1:0]       SrcValidD;
    logic [NUM_SRC*REG_W-1:0] SrcE;
    logic [NUM_SRC-1:0]       SrcValidE;
    logic                     McStartD;
    logic                     McStartE;
    logic [REG_W-1:0]         McDestE;
    logic                     MemtoRegE, MemtoRegM;
    logic                     RegWriteE, RegWriteM, RegWriteW;
    logic [REG_W-1:0]         WriteRegE, WriteRegM, WriteRegW;
    logic                     StallF, StallD, FlushE;
    logic [NUM_SRC-1:0]       ForwardD;
    logic [2*NUM_SRC-1:0]     ForwardE;
    logic                     McBusy, McDone, McErr;
    logic [STALL_CNT_W-1:0]   StallCount;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_W(REG_W), .NUM_SRC(NUM_SRC), .MC_LATENCY(MC_LATENCY), .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .BranchD(BranchD),
        .SrcD(SrcD), .SrcValidD(SrcValidD), .SrcE(SrcE), .SrcValidE(SrcValidE),
        .McStartD(McStartD), .McStartE(McStartE), .McDestE(McDestE),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardD(ForwardD), .ForwardE(ForwardE),
        .McBusy(McBusy), .McDone(McDone), .McErr(McErr), .StallCount(StallCount)
    );

    task automatic clear_inputs();
        BranchD = 0; SrcD = '0; SrcValidD = '0; SrcE = '0; SrcValidE = '0;
        McStartD = 0; McStartE = 0; McDestE = '0;
        MemtoRegE = 0; MemtoRegM = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    // Issue a multi-cycle op; returns in cycle t+1 with McStartE low, 1 time unit after negedge.
    task automatic issue(input logic [REG_W-1:0] dest);
        @(negedge clk);
        McStartE = 1; McDestE = dest;
        @(negedge clk);
        McStartE = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; McStartE = 1; McDestE = 5'd5;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if ({McBusy, McDone, McErr} !== 3'b000) begin n_fail++; $display("FAIL reset_mc: got %b expected 000", {McBusy, McDone, McErr}); end
        n_cmp++; if (StallCount !== 16'd0) begin n_fail++; $display("FAIL reset_stallcount: got %0d expected 0", StallCount); end
        n_cmp++; if ({StallF, StallD, FlushE, ForwardD, ForwardE} !== 12'd0) begin n_fail++; $display("FAIL reset_comb: got %b expected 0", {StallF, StallD, FlushE, ForwardD, ForwardE}); end
        @(negedge clk);
        reset = 0;
        #1;
        n_cmp++; if (McBusy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", McBusy); end
        @(negedge clk);
        McStartE = 0;
        #1;
        n_cmp++; if (McBusy !== 1'b1) begin n_fail++; $display("FAIL busy_after_release: got %b expected 1", McBusy); end
        // Abort the op with reset in its second busy cycle: no McDone may follow.
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        n_cmp++; if ({McBusy, McDone} !== 2'b00) begin n_fail++; $display("FAIL midop_reset: got %b expected 00", {McBusy, McDone}); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_cmp++; if ({McBusy, McDone} !== 2'b00) begin n_fail++; $display("FAIL midop_no_done c%0d: got %b expected 00", k, {McBusy, McDone}); end
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        @(negedge clk);
        SrcE = {5'd3, 5'd2, 5'd1}; SrcValidE = 3'b111;
        RegWriteM = 1; WriteRegM = 5'd2; RegWriteW = 1; WriteRegW = 5'd2;
        #1;
        n_cmp++; if (ForwardE !== 6'b00_10_00) begin n_fail++; $display("FAIL fwdE_m_prio: got %b expected 001000", ForwardE); end
        WriteRegM = 5'd0; WriteRegW = 5'd3;
        #1;
        n_cmp++; if (ForwardE !== 6'b01_00_00) begin n_fail++; $display("FAIL fwdE_w: got %b expected 010000", ForwardE); end
        SrcValidE = 3'b011;
        #1;
        n_cmp++; if (ForwardE !== 6'b00_00_00) begin n_fail++; $display("FAIL fwdE_invalid: got %b expected 000000", ForwardE); end
        SrcD = {5'd3, 5'd2, 5'd1}; SrcValidD = 3'b111; WriteRegM = 5'd2;
        #1;
        n_cmp++; if (ForwardD !== 3'b010) begin n_fail++; $display("FAIL fwdD: got %b expected 010", ForwardD); end
        SrcE = '0; SrcValidE = 3'b111; WriteRegM = 5'd0; WriteRegW = 5'd0;
        #1;
        n_cmp++; if (ForwardE !== 6'b0) begin n_fail++; $display("FAIL fwdE_r0: got %b expected 000000", ForwardE); end
    endtask

    task automatic test_lwstall();
        clear_inputs();
        @(negedge clk);
        MemtoRegE = 1; WriteRegE = 5'd3; SrcD = {5'd3, 5'd2, 5'd1}; SrcValidD = 3'b111;
        #1;
        n_cmp++; if ({StallF, StallD, FlushE} !== 3'b111) begin n_fail++; $display("FAIL lwstall_src2: got %b expected 111", {StallF, StallD, FlushE}); end
        SrcValidD = 3'b011;
        #1;
        n_cmp++; if ({StallF, StallD, FlushE} !== 3'b000) begin n_fail++; $display("FAIL lwstall_invalid: got %b expected 000", {StallF, StallD, FlushE}); end
    endtask

    task automatic test_branchstall();
        clear_inputs();
        @(negedge clk);
        BranchD = 1; SrcD = {5'd0, 5'd0, 5'd1}; SrcValidD = 3'b001; RegWriteE = 1; WriteRegE = 5'd1;
        #1;
        n_cmp++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL branch_e: got %b expected 1", StallD); end
        WriteRegE = 5'd0;
        #1;
        n_cmp++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL branch_r0: got %b expected 0", StallD); end
        RegWriteE = 0; MemtoRegM = 1; WriteRegM = 5'd1;
        #1;
        n_cmp++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL branch_m_load: got %b expected 1", StallD); end
        BranchD = 0;
        #1;
        n_cmp++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL branch_off: got %b expected 0", StallD); end
    endtask

    task automatic test_mc_stall();
        logic [STALL_CNT_W-1:0] sc0;
        clear_inputs();
        do_reset();
        sc0 = StallCount;
        SrcD = {5'd0, 5'd5, 5'd0}; SrcValidD = 3'b010;
        issue(5'd5);
        for (int k = 1; k <= MC_LATENCY; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            n_cmp++; if ({McBusy, McDone, StallD} !== {1'b1, (k == MC_LATENCY), (k < MC_LATENCY)}) begin
                n_fail++; $display("FAIL mc_raw c%0d: got %b expected %b", k, {McBusy, McDone, StallD}, {1'b1, (k == MC_LATENCY), (k < MC_LATENCY)});
            end
        end
        @(negedge clk); #1;
        n_cmp++; if ({McBusy, McDone, StallD} !== 3'b000) begin n_fail++; $display("FAIL mc_raw_end: got %b expected 000", {McBusy, McDone, StallD}); end
        SrcD = '0; SrcValidD = '0; McStartD = 1;
        issue(5'd5);
        for (int k = 1; k <= MC_LATENCY; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            n_cmp++; if ({McBusy, McDone, StallD} !== {1'b1, (k == MC_LATENCY), (k < MC_LATENCY)}) begin
                n_fail++; $display("FAIL mc_struct c%0d: got %b expected %b", k, {McBusy, McDone, StallD}, {1'b1, (k == MC_LATENCY), (k < MC_LATENCY)});
            end
        end
        @(negedge clk);
        McStartD = 0;
        #1;
        n_cmp++; if (StallCount - sc0 !== 16'd6) begin n_fail++; $display("FAIL stallcount_delta: got %0d expected 6", StallCount - sc0); end
        n_cmp++; if (McErr !== 1'b0) begin n_fail++; $display("FAIL mc_err_clean: got %b expected 0", McErr); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        do_reset();
        SrcD = {5'd0, 5'd0, 5'd9}; SrcValidD = 3'b001;
        issue(5'd5);
        @(negedge clk);
        McStartE = 1; McDestE = 5'd9;
        #1;
        n_cmp++; if (McErr !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b expected 0", McErr); end
        @(negedge clk);
        McStartE = 0;
        #1;
        n_cmp++; if ({McErr, McBusy, McDone, StallD} !== 4'b1100) begin n_fail++; $display("FAIL err_set_noreload: got %b expected 1100", {McErr, McBusy, McDone, StallD}); end
        @(negedge clk); #1;
        n_cmp++; if ({McBusy, McDone} !== 2'b11) begin n_fail++; $display("FAIL err_done_timing: got %b expected 11", {McBusy, McDone}); end
        McStartE = 1; McDestE = 5'd11; SrcD = {5'd0, 5'd0, 5'd11};
        #1;
        n_cmp++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL done_no_stall: got %b expected 0", StallD); end
        @(negedge clk);
        McStartE = 0;
        #1;
        for (int k = 1; k <= MC_LATENCY; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            n_cmp++; if ({McErr, McBusy, McDone, StallD} !== {2'b11, (k == MC_LATENCY), (k < MC_LATENCY)}) begin
                n_fail++; $display("FAIL b2b c%0d: got %b expected %b", k, {McErr, McBusy, McDone, StallD}, {2'b11, (k == MC_LATENCY), (k < MC_LATENCY)});
            end
        end
        @(negedge clk); #1;
        n_cmp++; if ({McErr, McBusy, McDone} !== 3'b100) begin n_fail++; $display("FAIL b2b_end: got %b expected 100", {McErr, McBusy, McDone}); end
        do_reset();
        n_cmp++; if (McErr !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear: got %b expected 0", McErr); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_lwstall();
        test_branchstall();
        test_mc_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
